import_alu_arbiter: RTL and testbench
=====================================

IMPORT_ALU_ARBITER -- requirements
Module: import_alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles from operand issue to alu_result sampling (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-006 SHALL have port req_sel  input  2  per-requester arith/logic select.
REQ-007 SHALL have port req_op  input  4  per-requester operation code, [2i+1:2i].
REQ-008 SHALL have port req_a, req_b  input  16 each  per-requester 8-bit operands, [8i+7:8i].
REQ-009 SHALL have port alu_sel, alu_op, alu_a, alu_b  output  1/2/8/8  drive to shared ALU.
REQ-010 SHALL have port alu_result  input  16  shared ALU result.
REQ-011 SHALL have port resp_valid  output  2  per-requester result valid.
REQ-012 SHALL have port resp_ready  input  2  per-requester result accept.
REQ-013 SHALL have port resp_data  output  32  per-requester result, [16i+15:16i].
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req_valid bit high, SHALL grant one requester, assert req_ready[g] combinationally that cycle, register sel/op/a/b of g, move to EXEC.
REQ-017 Arbitration SHALL be round-robin: single valid wins; both valid -> grant requester not equal to last_grant; last_grant updated on each grant.
REQ-018 req_ready SHALL be asserted only in IDLE, at most one bit, for exactly one cycle per grant.
REQ-019 alu_sel/alu_op/alu_a/alu_b SHALL come from the operand registers, stable through EXEC; values hold outside EXEC.
REQ-020 EXEC: a cycle counter SHALL count from 0; when it equals ALU_LAT-1, alu_result SHALL be registered into result register of g and FSM moves to RESP.
REQ-021 RESP: resp_valid[g] SHALL be high, resp_data[g] stable, until resp_ready[g] sampled high; then FSM returns to IDLE the next cycle.
REQ-022 resp_valid of the non-granted requester SHALL stay 0; resp_data of a requester SHALL hold its last result until overwritten.
REQ-023 Accept-to-resp_valid latency SHALL be ALU_LAT+1 cycles; minimum grant-to-grant spacing ALU_LAT+2 cycles.
REQ-024 Requesters SHALL hold valid and operands until ready; a req_valid arriving or dropping while busy SHALL be ignored until IDLE.
REQ-025 resp_ready asserted outside RESP, or for the non-granted requester, SHALL have no effect.
REQ-026 No result width truncation: alu_result passes 16 bits unchanged.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, counter=0, last_grant=1 (requester 0 wins first tie), operand/result registers, all alu_*, req_ready, resp_valid, resp_data, busy = 0.
REQ-028 Reset mid-EXEC or mid-RESP SHALL drop the transaction with no response; first cycle after release behaves as IDLE.

Verification (bench ALU model: sel0 op00 a+b, op01 a-b; sel1 op00 a&b, op01 a|b; combinational)
REQ-029 Single op: req0 sel=0 op=00 a=20 b=10, ALU_LAT=1 -> req_ready[0] same cycle, resp_valid[0] 2 cycles later, resp_data[15:0]=30.
REQ-030 Tie: both valid from reset, req0 add 20+10, req1 sel=1 op=00 60&15 -> req0 served first (30), then req1 (12), grants alternate.
REQ-031 Back-pressure: hold resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_data stay constant, busy=1, no req_ready asserted.
REQ-032 Latency: ALU_LAT=3, req1 sub 60-15 -> resp_valid[1] 4 cycles after accept, value 45; alu_* stable through EXEC.
REQ-033 Reset mid-EXEC: assert rst_n=0 during EXEC -> all outputs 0 immediately, no resp_valid after release, next request served normally.
REQ-034 Continuous valid on req0 only -> repeated grants to req0 every ALU_LAT+2 cycles with resp_ready tied high.

Source files
------------

// File: rtl/import_alu_arbiter.sv
// ---------------------------------------------------------------------------
// import_alu_arbiter
// Shares one multi-cycle ALU between two requesters. A round-robin arbiter
// picks a requester while idle, latches its operands, drives them to the ALU
// for ALU_LAT cycles, captures the 16-bit result into that requester's result
// register and holds resp_valid until the requester accepts it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (bit i = req i)
//   req_sel/req_op          per-requester select and opcode ([2i+1:2i])
//   req_a/req_b             per-requester 8-bit operands ([8i+7:8i])
//   alu_sel/op/a/b          operands driven to the shared ALU
//   alu_result              16-bit result returned by the shared ALU
//   resp_valid/resp_ready   per-requester response handshake
//   resp_data               per-requester 16-bit result ([16i+15:16i])
//   busy                    high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module import_alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_sel,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        alu_sel,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [15:0] alu_result,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the cycle the ALU output is sampled.
    localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  cnt_r;
    logic        grant_r;
    logic        last_grant_r;
    logic        sel_r;
    logic [1:0]  op_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] res0_r;
    logic [15:0] res1_r;
    logic        any_valid_s;
    logic        grant_s;
    logic        lat_done_s;

    assign any_valid_s = |req_valid;
    assign lat_done_s  = (cnt_r == LAT_LAST);

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Next-state decode for the IDLE -> EXEC -> RESP transaction sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (lat_done_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                // Only the granted requester's accept can retire the response.
                if (resp_ready[grant_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Accept strobe, same-cycle in IDLE; gated by rst_n so it is quiet during reset.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_r == IDLE) && any_valid_s) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // State register and ALU latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == EXEC) && !lat_done_s) begin
                cnt_r <= cnt_r + 2'd1;
            end else begin
                cnt_r <= 2'd0;
            end
        end
    end

    // Grant bookkeeping and operand capture on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            sel_r        <= 1'b0;
            op_r         <= 2'd0;
            a_r          <= 8'd0;
            b_r          <= 8'd0;
        end else if ((state_r == IDLE) && any_valid_s) begin
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
            sel_r        <= grant_s ? req_sel[1]    : req_sel[0];
            op_r         <= grant_s ? req_op[3:2]   : req_op[1:0];
            a_r          <= grant_s ? req_a[15:8]   : req_a[7:0];
            b_r          <= grant_s ? req_b[15:8]   : req_b[7:0];
        end else begin
            grant_r      <= grant_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Per-requester result registers; each keeps its last result until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_r <= 16'd0;
            res1_r <= 16'd0;
        end else if ((state_r == EXEC) && lat_done_s) begin
            if (grant_r) begin
                res1_r <= alu_result;
            end else begin
                res0_r <= alu_result;
            end
        end else begin
            res0_r <= res0_r;
            res1_r <= res1_r;
        end
    end

    assign alu_sel    = sel_r;
    assign alu_op     = op_r;
    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign busy       = (state_r != IDLE);
    assign resp_valid = (state_r == RESP) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data  = {res1_r, res0_r};

endmodule

// File: tb/tb_import_alu_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for import_alu_arbiter. A transaction-level model (grant,
// response due time, per-requester last result) predicts every output on
// every cycle of the ALU_LAT=1 instance; directed sequences add literal
// expectations. A second instance with ALU_LAT=3 covers the longer latency.
// ---------------------------------------------------------------------------
module tb_import_alu_arbiter;

    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_sel, resp_valid, resp_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b, alu_result;
    logic        alu_sel;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [31:0] resp_data;
    logic        busy;

    logic [1:0]  req_valid3, req_ready3, req_sel3, resp_valid3, resp_ready3;
    logic [3:0]  req_op3;
    logic [15:0] req_a3, req_b3, alu_result3;
    logic        alu_sel3;
    logic [1:0]  alu_op3;
    logic [7:0]  alu_a3, alu_b3;
    logic [31:0] resp_data3;
    logic        busy3;

    int n_checks = 0;
    int n_pass   = 0;

    // Shared ALU behaviour used by the bench.
    function automatic logic [15:0] alu_f(logic s, logic [1:0] op, logic [7:0] a, logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'd0, a};
        wb = {8'd0, b};
        case ({s, op})
            3'b000:  return wa + wb;
            3'b001:  return wa - wb;
            3'b100:  return wa & wb;
            3'b101:  return wa | wb;
            default: return 16'd0;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_sel, alu_op, alu_a, alu_b);
    assign alu_result3 = alu_f(alu_sel3, alu_op3, alu_a3, alu_b3);

    import_alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    import_alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_sel(req_sel3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
        .alu_sel(alu_sel3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
        .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic s, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_sel[i]       = s;
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        m_active, m_last, m_g, m_sel, pick;
    logic [1:0]  m_op, exp_ready, exp_rv;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_res;
    logic [15:0] m_data [2];
    int          m_cyc = 0;
    int          m_rdy_at = 0;

    // Compare every output against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_active = 1'b0; m_last = 1'b1; m_g = 1'b0;
            m_sel = 1'b0; m_op = 2'd0; m_a = 8'd0; m_b = 8'd0;
            m_data[0] = 16'd0; m_data[1] = 16'd0;
        end
        pick      = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        exp_ready = (rst_n && !m_active && (req_valid != 2'b00)) ? (2'b01 << pick) : 2'b00;
        exp_rv    = (m_active && (m_cyc >= m_rdy_at)) ? (2'b01 << m_g) : 2'b00;
        chk("req_ready",  32'(req_ready),  32'(exp_ready));
        chk("busy",       32'(busy),       32'(m_active));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_data",  resp_data,       {m_data[1], m_data[0]});
        chk("alu_drive",  32'({alu_sel, alu_op, alu_a, alu_b}), 32'({m_sel, m_op, m_a, m_b}));
        if (rst_n) begin
            if (!m_active && (req_valid != 2'b00)) begin
                m_active = 1'b1;
                m_g      = pick;
                m_last   = pick;
                m_sel    = req_sel[pick];
                m_op     = req_op[2*pick +: 2];
                m_a      = req_a[8*pick +: 8];
                m_b      = req_b[8*pick +: 8];
                m_res    = alu_f(m_sel, m_op, m_a, m_b);
                m_rdy_at = m_cyc + LAT + 1;
            end else if (m_active && (m_cyc >= m_rdy_at) && resp_ready[m_g]) begin
                m_active = 1'b0;
            end
            if (m_active && (m_cyc + 1 == m_rdy_at)) begin
                m_data[m_g] = m_res;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] pend, rdy_seen;
    int         last_g, n_g;

    initial begin
        rst_n = 1'b1;
        req_valid = 2'b00; req_sel = 2'b00; req_op = 4'd0; req_a = 16'd0; req_b = 16'd0;
        resp_ready = 2'b00;
        req_valid3 = 2'b00; req_sel3 = 2'b00; req_op3 = 4'd0; req_a3 = 16'd0; req_b3 = 16'd0;
        resp_ready3 = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", resp_data, 32'd0);
        rst_n = 1'b1;

        // Single add, ALU_LAT=1.
        set_req(0, 1'b0, 2'b00, 8'd20, 8'd10);
        req_valid = 2'b01;
        #3 chk("single_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        #3 chk("single_busy", 32'(busy), 32'd1);
        chk("single_rv_early", 32'(resp_valid), 32'd0);
        step();
        #3 chk("single_rv", 32'(resp_valid), 32'd1);
        chk("single_data", 32'(resp_data[15:0]), 32'd30);
        resp_ready = 2'b01;
        step();
        #3 chk("single_idle", 32'(busy), 32'd0);
        chk("single_hold", 32'(resp_data[15:0]), 32'd30);

        // Tie from reset: req0 first, then req1, with back-pressure on req1.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 1'b0, 2'b00, 8'd20, 8'd10);
        set_req(1, 1'b1, 2'b00, 8'd60, 8'd15);
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #3 chk("tie_first", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b10;
        #3 chk("tie_no_ready", 32'(req_ready), 32'd0);
        step();
        #3 chk("tie_rv0", 32'(resp_valid), 32'd1);
        chk("tie_data0", 32'(resp_data[15:0]), 32'd30);
        step();
        #3 chk("tie_second", 32'(req_ready), 32'd2);
        resp_ready = 2'b00;
        step();
        req_valid = 2'b00;
        step();
        set_req(0, 1'b0, 2'b01, 8'd7, 8'd2);
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #3 chk("bp_rv", 32'(resp_valid), 32'd2);
            chk("bp_data", 32'(resp_data[31:16]), 32'd12);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            resp_ready = 2'b01;
            step();
        end
        resp_ready = 2'b10;
        #3 chk("bp_rv_last", 32'(resp_valid), 32'd2);
        step();
        #3 chk("bp_regrant", 32'(req_ready), 32'd1);
        resp_ready = 2'b11;
        step();
        req_valid = 2'b00;
        step();
        #3 chk("sub_data", 32'(resp_data[15:0]), 32'd5);
        step();

        // Reset in the middle of EXEC.
        set_req(0, 1'b0, 2'b01, 8'd9, 8'd3);
        req_valid = 2'b01;
        #3 chk("rst_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_alu", 32'({alu_sel, alu_op, alu_a, alu_b}), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3 chk("rst_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        set_req(1, 1'b1, 2'b01, 8'hA0, 8'h05);
        req_valid = 2'b10;
        #3 chk("post_rst_grant", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b00;
        step();
        #3 chk("post_rst_data", 32'(resp_data[31:16]), 32'h00A5);
        step();

        // Continuous valid on req0 with resp_ready high.
        set_req(0, 1'b1, 2'b01, 8'h30, 8'h03);
        req_valid = 2'b01;
        last_g = -1;
        n_g = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (req_ready[0]) begin
                if (last_g >= 0) chk("rr_spacing", 32'(k - last_g), 32'(LAT + 2));
                last_g = k;
                n_g++;
            end
            step();
        end
        chk("rr_count", 32'(n_g), 32'd4);
        req_valid = 2'b00;
        repeat (3) step();

        // Randomized traffic; requesters hold valid until accepted.
        pend = 2'b00;
        rdy_seen = 2'b00;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rdy_seen[i]) begin
                    pend[i] = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    req_valid[i] = 1'b1;
                    set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            8'($urandom), 8'($urandom));
                end
            end
            resp_ready = 2'($urandom_range(0, 3));
            #3 rdy_seen = req_ready;
            step();
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (4) step();

        // ALU_LAT=3 instance: req1 subtract, four cycles to response.
        req_sel3 = 2'b00;
        req_op3 = 4'b0100;
        req_a3 = {8'd60, 8'd0};
        req_b3 = {8'd15, 8'd0};
        req_valid3 = 2'b10;
        #3 chk("lat3_ready", 32'(req_ready3), 32'd2);
        step();
        req_valid3 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #3 chk("lat3_rv_early", 32'(resp_valid3), 32'd0);
            chk("lat3_alu", 32'({alu_sel3, alu_op3, alu_a3, alu_b3}),
                32'({1'b0, 2'b01, 8'd60, 8'd15}));
            step();
        end
        #3 chk("lat3_rv", 32'(resp_valid3), 32'd2);
        chk("lat3_data", 32'(resp_data3[31:16]), 32'd45);
        resp_ready3 = 2'b10;
        step();
        #3 chk("lat3_idle", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
